// File: rtl/fetch_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_ctrl : fetch-stage controller, one imem transaction per PC      |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h80000000,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [31:0] F_pc_i,
  input  logic        F_stall_i,
  input  logic        flush_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] f_default_pc_o,
  output logic        f_busy_o,
  output logic        f_valid_o,
  output logic [31:0] f_instr_o,
  output logic [31:0] f_pc_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_VALID = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc_q;
  logic        r_valid;
  logic [31:0] r_instr;
  logic [31:0] r_pc;
  logic        w_capture;
  logic        w_release;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  w_state_nxt = S_REQ;
      S_REQ: begin
        if (imem_gnt_i) w_state_nxt = flush_i ? S_DRAIN : S_WAIT;
      end
      S_WAIT: begin
        if (imem_rvalid_i)  w_state_nxt = flush_i ? S_REQ : S_VALID;
        else if (flush_i)   w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (imem_rvalid_i) w_state_nxt = S_REQ;
      end
      S_VALID: begin
        if (flush_i || !F_stall_i) w_state_nxt = S_REQ;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_capture = (r_state == S_WAIT)  && imem_rvalid_i && !flush_i;
  assign w_release = (r_state == S_VALID) && (flush_i || !F_stall_i);

  // f_instr_o returns to NOP whenever the valid flag drops.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_pc_q  <= RESET_PC;
      r_valid <= 1'b0;
      r_instr <= NOP_INSTR;
      r_pc    <= RESET_PC;
    end else begin
      if ((r_state == S_REQ) && imem_gnt_i && !flush_i) begin
        r_pc_q <= F_pc_i;
      end
      if (w_capture) begin
        r_valid <= 1'b1;
        r_instr <= imem_rdata_i;
        r_pc    <= r_pc_q;
      end else if (w_release) begin
        r_valid <= 1'b0;
        r_instr <= NOP_INSTR;
      end
    end
  end

  assign imem_req_o     = (r_state == S_REQ);
  assign imem_addr_o    = F_pc_i;
  assign f_default_pc_o = F_pc_i + 32'd4;
  // Flush masks busy so the redirect PC is loaded on the flush edge.
  assign f_busy_o       = (r_state != S_VALID) && !flush_i;
  assign f_valid_o      = r_valid;
  assign f_instr_o      = r_instr;
  assign f_pc_o         = r_pc;

endmodule
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_fetch_ctrl : directed + randomized bench with transaction model    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_fetch_ctrl;

  localparam logic [31:0] C_RESET_PC = 32'h80000000;
  localparam logic [31:0] C_NOP      = 32'h00000013;

  logic        clk_i;
  logic        rst_n_i;
  logic [31:0] F_pc_i;
  logic        F_stall_i;
  logic        flush_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic [31:0] f_default_pc_o;
  logic        f_busy_o;
  logic        f_valid_o;
  logic [31:0] f_instr_o;
  logic [31:0] f_pc_o;

  fetch_ctrl #(.RESET_PC(C_RESET_PC), .NOP_INSTR(C_NOP)) dut (
    .clk_i          (clk_i),
    .rst_n_i        (rst_n_i),
    .F_pc_i         (F_pc_i),
    .F_stall_i      (F_stall_i),
    .flush_i        (flush_i),
    .imem_req_o     (imem_req_o),
    .imem_addr_o    (imem_addr_o),
    .imem_gnt_i     (imem_gnt_i),
    .imem_rvalid_i  (imem_rvalid_i),
    .imem_rdata_i   (imem_rdata_i),
    .f_default_pc_o (f_default_pc_o),
    .f_busy_o       (f_busy_o),
    .f_valid_o      (f_valid_o),
    .f_instr_o      (f_instr_o),
    .f_pc_o         (f_pc_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int n_pass  = 0;
  int n_total = 0;

  // Stimulus knobs
  logic        drv_rst   = 1'b0;
  logic [31:0] drv_pc    = C_RESET_PC;
  logic        drv_stall = 1'b0;
  logic        drv_flush = 1'b0;
  logic        drv_gnt   = 1'b0;
  logic        drv_spur  = 1'b0;
  int unsigned drv_lat   = 0;
  logic [31:0] drv_data  = 32'h0;

  // Transaction-level reference: boot cycle, one outstanding fetch, presented instruction
  logic        m_boot;
  logic        m_out;
  logic        m_stale;
  logic [31:0] m_txn_pc;
  logic        m_have;
  logic [31:0] m_instr;
  logic [31:0] m_pc;

  // Memory responder
  logic        mem_pending;
  int unsigned mem_cnt;
  logic [31:0] mem_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_total++;
    assert (obs === exp_v) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
  endtask

  task automatic model_reset();
    m_boot      = 1'b1;
    m_out       = 1'b0;
    m_stale     = 1'b0;
    m_txn_pc    = 32'h0;
    m_have      = 1'b0;
    m_instr     = C_NOP;
    m_pc        = C_RESET_PC;
    mem_pending = 1'b0;
    mem_cnt     = 0;
    mem_data    = 32'h0;
  endtask

  function automatic logic model_req();
    return !m_boot && !m_out && !m_have;
  endfunction

  task automatic cycle();
    logic exp_req;
    logic rv;
    logic spur;
    @(negedge clk_i);
    rst_n_i   = drv_rst;
    F_pc_i    = drv_pc;
    F_stall_i = drv_stall;
    flush_i   = drv_flush;
    exp_req   = rst_n_i && model_req();
    imem_gnt_i = exp_req && drv_gnt;
    rv   = mem_pending && (mem_cnt == 0);
    spur = !mem_pending && drv_spur && ($urandom_range(0, 3) == 0);
    imem_rvalid_i = rv || spur;
    imem_rdata_i  = rv ? mem_data : $urandom();
    #1;
    chk("req", {31'd0, imem_req_o}, {31'd0, exp_req});
    if (exp_req) chk("addr", imem_addr_o, drv_pc);
    chk("busy", {31'd0, f_busy_o}, {31'd0, !m_have && !drv_flush});
    chk("dflt_pc", f_default_pc_o, drv_pc + 32'd4);
    chk("valid", {31'd0, f_valid_o}, {31'd0, m_have});
    chk("instr", f_instr_o, m_instr);
    chk("f_pc", f_pc_o, m_pc);
    @(posedge clk_i);
    if (!rst_n_i) begin
      model_reset();
    end else begin
      if (m_boot) begin
        m_boot = 1'b0;
      end else if (m_have) begin
        if (drv_flush || !drv_stall) begin
          m_have  = 1'b0;
          m_instr = C_NOP;
        end
      end else if (m_out) begin
        if (imem_rvalid_i) begin
          m_out = 1'b0;
          if (!m_stale && !drv_flush) begin
            m_have  = 1'b1;
            m_instr = imem_rdata_i;
            m_pc    = m_txn_pc;
          end
        end else if (drv_flush) begin
          m_stale = 1'b1;
        end
      end else if (imem_gnt_i) begin
        m_out    = 1'b1;
        m_stale  = drv_flush;
        m_txn_pc = drv_pc;
      end
      if (rv) mem_pending = 1'b0;
      if (imem_gnt_i) begin
        mem_pending = 1'b1;
        mem_cnt     = drv_lat;
        mem_data    = drv_data;
      end else if (mem_pending && mem_cnt > 0) begin
        mem_cnt--;
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n_i = 1'b0; F_pc_i = C_RESET_PC; F_stall_i = 1'b0; flush_i = 1'b0;
    imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = 32'h0;
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_req", {31'd0, imem_req_o}, 32'd0);
    chk("rst_valid", {31'd0, f_valid_o}, 32'd0);
    chk("rst_instr", f_instr_o, C_NOP);
    chk("rst_pc", f_pc_o, C_RESET_PC);
    chk("rst_busy", {31'd0, f_busy_o}, 32'd1);

    // First fetch, zero-wait memory
    drv_rst = 1'b1; drv_gnt = 1'b1; drv_lat = 0; drv_data = 32'h00500093;
    cycle();
    #1;
    chk("t1_req", {31'd0, imem_req_o}, 32'd1);
    chk("t1_addr", imem_addr_o, 32'h80000000);
    cycle();
    cycle();
    #1;
    chk("t1_valid", {31'd0, f_valid_o}, 32'd1);
    chk("t1_instr", f_instr_o, 32'h00500093);
    chk("t1_pc", f_pc_o, 32'h80000000);
    chk("t1_dflt", f_default_pc_o, 32'h80000004);
    cycle();
    drv_pc = 32'h80000004;

    // Grant withheld for 3 cycles, response 2 cycles after grant
    drv_gnt = 1'b0;
    repeat (3) cycle();
    drv_gnt = 1'b1; drv_lat = 1; drv_data = 32'h00A00113;
    cycle();
    drv_gnt = 1'b0;
    cycle();
    cycle();
    #1;
    chk("t2_valid", {31'd0, f_valid_o}, 32'd1);
    chk("t2_pc", f_pc_o, 32'h80000004);

    // Stall while an instruction is presented
    drv_stall = 1'b1;
    repeat (4) cycle();
    #1;
    chk("t3_instr_held", f_instr_o, 32'h00A00113);
    chk("t3_no_req", {31'd0, imem_req_o}, 32'd0);
    drv_stall = 1'b0;
    cycle();
    drv_pc = 32'h80000008;
    #1;
    chk("t3_req_after", {31'd0, imem_req_o}, 32'd1);

    // Flush while waiting; stale data must be dropped
    drv_gnt = 1'b1; drv_lat = 1; drv_data = 32'hDEADBEEF;
    cycle();
    drv_gnt = 1'b0; drv_flush = 1'b1;
    cycle();
    drv_flush = 1'b0; drv_pc = 32'h80000100;
    cycle();
    #1;
    chk("t4_req", {31'd0, imem_req_o}, 32'd1);
    chk("t4_addr", imem_addr_o, 32'h80000100);
    chk("t4_valid", {31'd0, f_valid_o}, 32'd0);
    drv_gnt = 1'b1; drv_lat = 0; drv_data = 32'h00100073;
    repeat (3) cycle();

    // Next-PC wrap
    drv_pc = 32'hFFFFFFFC;
    cycle();
    #1;
    chk("t5_wrap", f_default_pc_o, 32'h00000000);

    // Asynchronous reset while waiting for data
    drv_pc = 32'h80000200;
    for (int i = 0; i < 10 && !model_req(); i++) cycle();
    drv_gnt = 1'b1; drv_lat = 3; drv_data = 32'h12345678;
    cycle();
    drv_gnt = 1'b0;
    cycle();
    @(negedge clk_i);
    #2;
    rst_n_i = 1'b0;
    #1;
    chk("t6_req", {31'd0, imem_req_o}, 32'd0);
    chk("t6_valid", {31'd0, f_valid_o}, 32'd0);
    chk("t6_instr", f_instr_o, C_NOP);
    chk("t6_pc", f_pc_o, C_RESET_PC);
    chk("t6_busy", {31'd0, f_busy_o}, 32'd1);
    model_reset();
    drv_rst = 1'b0;
    repeat (2) cycle();
    drv_rst = 1'b1;
    cycle();
    #1;
    chk("t6_req_after", {31'd0, imem_req_o}, 32'd1);

    // Randomized traffic
    drv_spur = 1'b1;
    for (int i = 0; i < 400; i++) begin
      drv_pc    = {$urandom()} & 32'hFFFFFFFC;
      drv_stall = ($urandom_range(0, 3) == 0);
      drv_flush = ($urandom_range(0, 9) == 0);
      drv_gnt   = ($urandom_range(0, 1) == 1);
      drv_lat   = $urandom_range(0, 3);
      drv_data  = $urandom();
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
